// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the general-purpose register file write path:
// address width, register count, the hard-wired zero register and the
// write-port controller state type.
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   // Register 0 reads as a constant; writes to it are swallowed in RUN.
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   // The init counter needs one extra bit: it counts 0..NUM_REGS so that the
   // cycle after the last init write can be told apart from the write itself.
   localparam int unsigned             INIT_CNT_W = REG_ADDR_W + 1;
   localparam logic [INIT_CNT_W-1:0]   INIT_END   = INIT_CNT_W'(NUM_REGS);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// ---------------------------------------------------------------------------
// wb_arb2
// Two-way writeback arbiter: turns a pair of valids into a one-hot (or zero)
// grant. Bit 0 is requester 0 (load/store unit), bit 1 is requester 1 (ALU).
//
// Build option:
//   REGFILE_WB_RR_EN defined   - round-robin: on a tie, the requester that was
//                                not granted most recently wins. The pointer
//                                moves only on a completed handshake and is
//                                cleared (req0 preferred) by reset and clear.
//   REGFILE_WB_RR_EN undefined - fixed priority, req0 wins every tie; no state.
//
// Ports:
//   valid   in  2  request valids {req1, req0}
//   clock   in  1  (RR only) system clock
//   reset_n in  1  (RR only) asynchronous active-low reset
//   clear   in  1  (RR only) synchronous pointer reset
//   advance in  1  (RR only) a granted request completed its handshake
//   grant   out 2  one-hot grant, never set for an invalid requester
// ---------------------------------------------------------------------------
module wb_arb2 (
   input  logic [1:0] valid,
`ifdef REGFILE_WB_RR_EN
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       advance,
`endif
   output logic [1:0] grant
);

`ifdef REGFILE_WB_RR_EN
   // High when requester 1 should win the next tie.
   logic prefer1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prefer1 <= 1'b0;
      end else if (clear) begin
         prefer1 <= 1'b0;
      end else if (advance) begin
         // Whoever was just served yields the next tie.
         prefer1 <= grant[0];
      end
   end

   always_comb begin
      grant = '0;
      if (valid[0] && (!valid[1] || !prefer1)) begin
         grant[0] = 1'b1;
      end else if (valid[1]) begin
         grant[1] = 1'b1;
      end
   end
`else
   always_comb begin
      grant    = '0;
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
   end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Write-port controller for the 32-entry register file. After reset (or a
// clear in RUN) it writes INIT_VALUE to every register, one per cycle, then
// shares the single write port between the load/store unit (req0) and the
// ALU (req1) with valid/ready handshakes. Accepted writes appear on the
// rf_write_* outputs one cycle after acceptance. Writes to register 0 are
// accepted but never reach the register file.
//
// Build option: REGFILE_WB_RR_EN selects round-robin arbitration (see wb_arb2);
// without it req0 has fixed priority.
//
// Parameters:
//   WORD_SIZE   width of write data
//   INIT_VALUE  value written to every register during initialization
//
// Ports:
//   clock            in   1          system clock, rising edge
//   reset_n          in   1          asynchronous active-low reset
//   clear            in   1          re-run initialization (ignored in INIT)
//   req0_valid       in   1          requester 0 has a writeback pending
//   req0_addr        in   5          requester 0 destination register
//   req0_data        in   WORD_SIZE  requester 0 writeback data
//   req0_ready       out  1          requester 0 accepted this cycle
//   req1_*                           same as req0_*, for requester 1
//   rf_write_enable  out  1          register file write enable
//   rf_write_addr    out  5          register file write address
//   rf_write_data    out  WORD_SIZE  register file write data
//   init_done        out  1          initialization complete
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
   import regfile_pkg::*;
#(
   parameter int unsigned           WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0]  INIT_VALUE = '0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   req0_valid,
   input  logic [REG_ADDR_W-1:0]  req0_addr,
   input  logic [WORD_SIZE-1:0]   req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [REG_ADDR_W-1:0]  req1_addr,
   input  logic [WORD_SIZE-1:0]   req1_data,
   output logic                   req1_ready,
   output logic                   rf_write_enable,
   output logic [REG_ADDR_W-1:0]  rf_write_addr,
   output logic [WORD_SIZE-1:0]   rf_write_data,
   output logic                   init_done
);

   wb_state_t              state, state_nxt;
   logic [INIT_CNT_W-1:0]  counter, counter_nxt;
   logic                   we_nxt;
   logic [REG_ADDR_W-1:0]  addr_nxt;
   logic [WORD_SIZE-1:0]   data_nxt;
   logic                   done_nxt;

   logic [1:0]             grant;
   logic                   accept_ok;
   logic                   hs0, hs1;
   logic [REG_ADDR_W-1:0]  sel_addr;
   logic [WORD_SIZE-1:0]   sel_data;

   // ------------------------------------------------------------------
   // Arbitration and handshakes
   // ------------------------------------------------------------------
`ifdef REGFILE_WB_RR_EN
   logic handshake;
   logic arb_clear;

   assign handshake = hs0 | hs1;
   assign arb_clear = clear & (state == RUN);
`endif

   wb_arb2 u_arb (
      .valid   ({req1_valid, req0_valid}),
`ifdef REGFILE_WB_RR_EN
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (arb_clear),
      .advance (handshake),
`endif
      .grant   (grant)
   );

   // A clear edge must not also complete a handshake, so the readies are
   // masked by clear as well as init_done.
   assign accept_ok  = init_done & ~clear;
   assign req0_ready = accept_ok & grant[0];
   assign req1_ready = accept_ok & grant[1];

   assign hs0 = req0_valid & req0_ready;
   assign hs1 = req1_valid & req1_ready;

   assign sel_addr = hs0 ? req0_addr : req1_addr;
   assign sel_data = hs0 ? req0_data : req1_data;

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= INIT;
         counter         <= '0;
         rf_write_enable <= 1'b0;
         rf_write_addr   <= '0;
         rf_write_data   <= '0;
         init_done       <= 1'b0;
      end else begin
         state           <= state_nxt;
         counter         <= counter_nxt;
         rf_write_enable <= we_nxt;
         rf_write_addr   <= addr_nxt;
         rf_write_data   <= data_nxt;
         init_done       <= done_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      we_nxt      = 1'b0;
      addr_nxt    = rf_write_addr;
      data_nxt    = rf_write_data;
      done_nxt    = init_done;

      unique case (state)
         INIT: begin
            if (counter == INIT_END) begin
               // Last init write (address 31) is on the outputs now; the
               // register file commits it on this edge.
               state_nxt = RUN;
               done_nxt  = 1'b1;
            end else begin
               we_nxt      = 1'b1;
               addr_nxt    = counter[REG_ADDR_W-1:0];
               data_nxt    = INIT_VALUE;
               counter_nxt = counter + 1'b1;
            end
         end

         RUN: begin
            if (clear) begin
               state_nxt   = INIT;
               counter_nxt = '0;
               done_nxt    = 1'b0;
            end else if ((hs0 || hs1) && (sel_addr != ZERO_REG)) begin
               // Accepted writes to register 0 leave the outputs untouched.
               we_nxt   = 1'b1;
               addr_nxt = sel_addr;
               data_nxt = sel_data;
            end
         end

         default: begin
            state_nxt = INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
   import regfile_pkg::*;

   localparam int unsigned WS = 32;
   localparam logic [WS-1:0] IV = 32'hA5A5_0F0F;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b1;
   logic                  clear = 1'b0;
   logic                  req0_valid = 1'b0;
   logic [REG_ADDR_W-1:0] req0_addr = '0;
   logic [WS-1:0]         req0_data = '0;
   logic                  req0_ready;
   logic                  req1_valid = 1'b0;
   logic [REG_ADDR_W-1:0] req1_addr = '0;
   logic [WS-1:0]         req1_data = '0;
   logic                  req1_ready;
   logic                  rf_write_enable;
   logic [REG_ADDR_W-1:0] rf_write_addr;
   logic [WS-1:0]         rf_write_data;
   logic                  init_done;

   always #5 clock = ~clock;

   regfile_wb_ctrl #(.WORD_SIZE(WS), .INIT_VALUE(IV)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .clear           (clear),
      .req0_valid      (req0_valid),
      .req0_addr       (req0_addr),
      .req0_data       (req0_data),
      .req0_ready      (req0_ready),
      .req1_valid      (req1_valid),
      .req1_addr       (req1_addr),
      .req1_data       (req1_data),
      .req1_ready      (req1_ready),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .init_done       (init_done)
   );

   // Register file driven by the controller outputs.
   logic [WS-1:0] rf_model [NUM_REGS];
   always @(posedge clock) begin
      if (rf_write_enable) rf_model[rf_write_addr] <= rf_write_data;
   end

   typedef struct {
      logic                  v0;
      logic [REG_ADDR_W-1:0] a0;
      logic [WS-1:0]         d0;
      logic                  v1;
      logic [REG_ADDR_W-1:0] a1;
      logic [WS-1:0]         d1;
      logic                  clr;
      logic                  e_r0;
      logic                  e_r1;
   } vec_t;

   typedef struct {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [WS-1:0]         data;
      logic                  done;
   } out_t;

   out_t                  sb[$];
   int                    n_checks = 0;
   int                    n_fail = 0;
   logic [REG_ADDR_W-1:0] exp_addr = '0;
   logic [WS-1:0]         exp_data = '0;
   logic                  exp_done = 1'b0;
   vec_t                  vecs [9];

   function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic clr, input logic e0, input logic e1);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.clr = clr; v.e_r0 = e0; v.e_r1 = e1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      clear = v.clr;
   endtask

   // Wait for the next edge and compare the registered outputs against the
   // oldest scoreboard entry ({we, addr, data, done}).
   task automatic edge_and_compare(input string tag);
      out_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check(tag, {rf_write_enable, rf_write_addr, rf_write_data, init_done},
               {e.we, e.addr, e.data, e.done});
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      out_t e;
      drive(v);
      #1;
      check({tag, ".ready"}, {req0_ready, req1_ready}, {v.e_r0, v.e_r1});
      e.we = 1'b0;
      if (v.clr && exp_done) begin
         exp_done = 1'b0;
      end else if (v.e_r0 && v.a0 != 0) begin
         e.we = 1'b1; exp_addr = v.a0; exp_data = v.d0;
      end else if (v.e_r1 && v.a1 != 0) begin
         e.we = 1'b1; exp_addr = v.a1; exp_data = v.d1;
      end
      e.addr = exp_addr; e.data = exp_data; e.done = exp_done;
      sb.push_back(e);
      edge_and_compare({tag, ".out"});
   endtask

   // n init writes with both requesters pending (they must not be served),
   // optionally followed by the init_done edge.
   task automatic init_seq(input string tag, input int n, input logic finish);
      out_t e;
      drive(mk(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0, 0, 0));
      for (int k = 0; k < n; k++) begin
         #1;
         check({tag, ".init_ready"}, {req0_ready, req1_ready}, 2'b00);
         exp_addr = REG_ADDR_W'(k); exp_data = IV;
         e.we = 1'b1; e.addr = exp_addr; e.data = exp_data; e.done = 1'b0;
         sb.push_back(e);
         edge_and_compare({tag, ".init_write"});
      end
      if (finish) begin
         #1;
         check({tag, ".init_ready"}, {req0_ready, req1_ready}, 2'b00);
         exp_done = 1'b1;
         e.we = 1'b0; e.addr = exp_addr; e.data = exp_data; e.done = 1'b1;
         sb.push_back(e);
         edge_and_compare({tag, ".init_done"});
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".outs"}, {rf_write_enable, rf_write_addr, rf_write_data, init_done}, '0);
      check({tag, ".ready"}, {req0_ready, req1_ready}, 2'b00);
   endtask

   initial begin
      // Run-phase vector table: {inputs, expected readies}.
      vecs[0] = mk(0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 1);
      vecs[1] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 0, 0);
`ifdef REGFILE_WB_RR_EN
      vecs[2] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[3] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 1);
      vecs[4] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[5] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 1);
      vecs[7] = mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1);
`else
      vecs[2] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[3] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[4] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[5] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 0);
      vecs[7] = mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 0);
`endif
      vecs[6] = mk(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 0, 1, 0);
      vecs[8] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0, 0, 0, 0);

      // Asynchronous reset, checked before any clock edge.
      req0_valid = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      check_reset_values("reset");
      @(negedge clock);
      reset_n = 1'b1;

      init_seq("boot", 32, 1'b1);
      check("boot.rf0",  64'(rf_model[0]),  64'(IV));
      check("boot.rf31", 64'(rf_model[31]), 64'(IV));

      for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
      check("rf5",      64'(rf_model[5]), 64'h0000_0000_DEAD_BEEF);
      check("rf1",      64'(rf_model[1]), 64'h11);
      check("rf0_kept", 64'(rf_model[0]), 64'(IV));

      // clear in RUN while req0 is valid: no accept on that edge, full re-init.
      run_vec("clear", mk(1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 0, 0));
      init_seq("reinit", 32, 1'b1);
      run_vec("post_clear", mk(1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 1, 0));
      run_vec("post_idle",  mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0, 0, 0, 0));
      check("rf6", 64'(rf_model[6]), 64'h66);

      // Reset in the middle of initialization (counter = 10).
      run_vec("clear2", mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 0));
      init_seq("partial", 10, 1'b0);
      reset_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      exp_addr = '0; exp_data = '0; exp_done = 1'b0;
      sb.delete();
      @(negedge clock);
      reset_n = 1'b1;
      init_seq("restart", 32, 1'b1);
      run_vec("final_req1", mk(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 0, 1));
      run_vec("final_idle", mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 0, 0));
      check("rf9", 64'(rf_model[9]), 64'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
